// File: rtl/mod_seq_monitor.sv
// Observes a mod-MOD counter: locks on the first 0 and checks each sample is prev+1 mod MOD.
// All outputs are registered one edge after the sample. en only qualifies sampling; the block never stalls.
module mod_seq_monitor #(
  parameter int MOD   = 14,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] q,
  input  logic             clr,
  output logic             locked,
  output logic             tc,
  output logic [CNT_W-1:0] wrap_count,
  output logic             err_seq,
  output logic             err_range,
  output logic [WIDTH-1:0] err_val,
  output logic [WIDTH-1:0] exp_val
);

  typedef enum logic [1:0] {SEARCH, LOCKED, ERROR} state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] exp_nxt;
  logic             q_bad;

  assign exp_nxt = (prev == LAST) ? '0 : prev + 1'b1;
  assign q_bad   = (q > LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      prev       <= '0;
      locked     <= 1'b0;
      tc         <= 1'b0;
      wrap_count <= '0;
      err_seq    <= 1'b0;
      err_range  <= 1'b0;
      err_val    <= '0;
      exp_val    <= '0;
    end else begin
      tc <= 1'b0;
      if (clr) begin
        state      <= SEARCH;
        prev       <= '0;
        locked     <= 1'b0;
        wrap_count <= '0;
        err_seq    <= 1'b0;
        err_range  <= 1'b0;
        err_val    <= '0;
        exp_val    <= '0;
      end else if (en) begin
        unique case (state)
          SEARCH: begin
            if (q_bad) begin
              state     <= ERROR;
              err_range <= 1'b1;
              err_val   <= q;
              exp_val   <= '0;
            end else if (q == '0) begin
              state  <= LOCKED;
              locked <= 1'b1;
              prev   <= '0;
            end
          end
          LOCKED: begin
            // Range violations are reported in preference to sequence violations.
            if (q_bad) begin
              state     <= ERROR;
              locked    <= 1'b0;
              err_range <= 1'b1;
              err_val   <= q;
              exp_val   <= exp_nxt;
            end else if (q == exp_nxt) begin
              prev <= q;
              if (q == '0) begin
                tc <= 1'b1;
                if (wrap_count != '1) wrap_count <= wrap_count + 1'b1;
              end
            end else begin
              state   <= ERROR;
              locked  <= 1'b0;
              err_seq <= 1'b1;
              err_val <= q;
              exp_val <= exp_nxt;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_seq_monitor.sv
// Directed bench for mod_seq_monitor: a default instance and a CNT_W=3 instance share stimulus.
module tb_mod_seq_monitor;
  localparam int MOD = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] q   = '0;
  logic       clr = 1'b0;

  logic       locked_a, tc_a, err_seq_a, err_range_a;
  logic [7:0] wrap_count_a;
  logic [3:0] err_val_a, exp_val_a;
  logic       locked_b, tc_b, err_seq_b, err_range_b;
  logic [2:0] wrap_count_b;
  logic [3:0] err_val_b, exp_val_b;

  mod_seq_monitor #(.MOD(14), .WIDTH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .q(q), .clr(clr),
    .locked(locked_a), .tc(tc_a), .wrap_count(wrap_count_a),
    .err_seq(err_seq_a), .err_range(err_range_a),
    .err_val(err_val_a), .exp_val(exp_val_a));

  mod_seq_monitor #(.MOD(14), .WIDTH(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .q(q), .clr(clr),
    .locked(locked_b), .tc(tc_b), .wrap_count(wrap_count_b),
    .err_seq(err_seq_b), .err_range(err_range_b),
    .err_val(err_val_b), .exp_val(exp_val_b));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: searching / locked on a last-seen value / halted by an error.
  bit m_locked, m_halted, m_tc, m_eseq, m_erng;
  int m_last, m_wraps, m_eval, m_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked = 0; m_halted = 0; m_tc = 0; m_eseq = 0; m_erng = 0;
      m_last = 0; m_wraps = 0; m_eval = 0; m_exp = 0;
    end else begin
      m_tc = 0;
      if (clr) begin
        m_locked = 0; m_halted = 0; m_eseq = 0; m_erng = 0;
        m_last = 0; m_wraps = 0; m_eval = 0; m_exp = 0;
      end else if (en && !m_halted) begin
        if (!m_locked) begin
          if (int'(q) >= MOD) begin
            m_halted = 1; m_erng = 1; m_eval = q; m_exp = 0;
          end else if (q == 0) begin
            m_locked = 1; m_last = 0;
          end
        end else begin
          int e;
          e = (m_last + 1) % MOD;
          if (int'(q) >= MOD) begin
            m_halted = 1; m_locked = 0; m_erng = 1; m_eval = q; m_exp = e;
          end else if (int'(q) == e) begin
            m_last = e;
            if (e == 0) begin m_tc = 1; m_wraps++; end
          end else begin
            m_halted = 1; m_locked = 0; m_eseq = 1; m_eval = q; m_exp = e;
          end
        end
      end
    end
  end

  int cyc = 0, tc_cnt = 0, last_tc = 0, tc_gap = 0;

  always @(negedge clk) begin
    cyc++;
    chk("locked",       locked_a,     m_locked);
    chk("tc",           tc_a,         m_tc);
    chk("wrap_count",   wrap_count_a, (m_wraps > 255) ? 255 : m_wraps);
    chk("err_seq",      err_seq_a,    m_eseq);
    chk("err_range",    err_range_a,  m_erng);
    chk("err_val",      err_val_a,    m_eval);
    chk("exp_val",      exp_val_a,    m_exp);
    chk("b_locked",     locked_b,     m_locked);
    chk("b_tc",         tc_b,         m_tc);
    chk("b_wrap_count", wrap_count_b, (m_wraps > 7) ? 7 : m_wraps);
    if (tc_a) begin
      tc_cnt++;
      tc_gap  = cyc - last_tc;
      last_tc = cyc;
    end
  end

  task automatic drive(input bit e, input int v, input bit c);
    @(negedge clk);
    en  = e;
    q   = 4'(v);
    clr = c;
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_locked", locked_a, 0);
    chk("rst_wrap", wrap_count_a, 0);
    chk("rst_err", {err_seq_a, err_range_a}, 0);
    rst = 1'b0;

    // Free run from 0: 43 samples, three wraps 14 samples apart.
    tc_cnt = 0;
    drive(1, 0, 0); settle();
    chk("t1_lock_first", locked_a, 1);
    for (int v = 1; v <= 42; v++) drive(1, v % MOD, 0);
    drive(0, 0, 0); settle();
    chk("t1_wraps", wrap_count_a, 3);
    chk("t1_tc_cnt", tc_cnt, 3);
    chk("t1_tc_gap", tc_gap, 14);

    // Start mid-count at 9: lock only on the first 0.
    drive(0, 0, 1);
    for (int v = 9; v <= 13; v++) drive(1, v, 0);
    settle();
    chk("t2_unlocked", locked_a, 0);
    drive(1, 0, 0); settle();
    chk("t2_lock", locked_a, 1);
    chk("t2_no_tc", tc_a, 0);
    for (int v = 1; v <= 14; v++) drive(1, v % MOD, 0);
    settle();
    chk("t2_tc", tc_a, 1);
    chk("t2_wraps", wrap_count_a, 1);

    // Sequence error 4,5,7; subsequent samples change nothing.
    for (int v = 1; v <= 5; v++) drive(1, v, 0);
    drive(1, 7, 0); settle();
    chk("t3_err_seq", err_seq_a, 1);
    chk("t3_err_val", err_val_a, 7);
    chk("t3_exp_val", exp_val_a, 6);
    chk("t3_unlocked", locked_a, 0);
    drive(1, 8, 0); drive(1, 0, 0); drive(1, 1, 0); settle();
    chk("t3_frozen_val", err_val_a, 7);
    chk("t3_frozen_wrap", wrap_count_a, 1);

    // Range error at prev=12, then clr with a coincident 0 sample.
    drive(0, 0, 1);
    for (int v = 0; v <= 12; v++) drive(1, v, 0);
    drive(1, 15, 0); settle();
    chk("t4_err_range", err_range_a, 1);
    chk("t4_err_seq", err_seq_a, 0);
    chk("t4_err_val", err_val_a, 15);
    chk("t4_exp_val", exp_val_a, 13);
    drive(1, 0, 1); settle();
    chk("t4_clr_locked", locked_a, 0);
    chk("t4_clr_err", err_range_a, 0);
    drive(1, 0, 0); settle();
    chk("t4_relock", locked_a, 1);

    // Nine periods: narrow tally saturates at 7, tc keeps pulsing.
    drive(0, 0, 1);
    tc_cnt = 0;
    for (int v = 0; v <= 9 * MOD; v++) drive(1, v % MOD, 0);
    drive(0, 0, 0); settle();
    chk("t5_wrap_a", wrap_count_a, 9);
    chk("t5_wrap_b", wrap_count_b, 7);
    chk("t5_tc_cnt", tc_cnt, 9);

    // Async reset one edge before a wrap.
    drive(0, 0, 1);
    for (int v = 0; v <= MOD + 13; v++) drive(1, v % MOD, 0);
    settle();
    chk("t6_pre_wrap", wrap_count_a, 1);
    @(negedge clk);
    en = 1; q = 0; clr = 0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_locked", locked_a, 0);
    chk("t6_rst_wrap", wrap_count_a, 0);
    @(negedge clk);
    rst = 1'b0;
    settle();
    chk("t6_no_tc", tc_a, 0);
    chk("t6_relock", locked_a, 1);
    drive(1, 1, 0); settle();
    chk("t6_still_locked", locked_a, 1);
    drive(0, 0, 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mod_seq_monitor.md
Name: mod_seq_monitor

Overview:
- Downstream observer for the mod-N counter family; the default configuration targets the mod-14 counter.
- Samples the counter's q bus every enabled clock and locks onto the count sequence at the first 0.
- Checks that every subsequent sample equals the previous value +1 modulo MOD.
- Emits a terminal-count pulse per wrap, keeps a saturating wrap tally, and latches sticky sequence/range errors for the testbench and for downstream logic.

Parameters:
- MOD, 14, counter modulus; legal q values are 0..MOD-1.
- WIDTH, 4, width of the observed count bus; 2^WIDTH >= MOD.
- CNT_W, 8, width of the wrap tally.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample qualifier; held high on every cycle the monitored counter advances.
- q  in  WIDTH  count value from the upstream counter.
- clr  in  1  synchronous clear of errors, tally and lock; returns the block to SEARCH.
- locked  out  1  high while state==LOCKED.
- tc  out  1  one-cycle pulse, the cycle after a valid MOD-1 -> 0 wrap is sampled.
- wrap_count  out  CNT_W  number of valid wraps since reset/clr; saturating.
- err_seq  out  1  sticky; a sequence mismatch was detected.
- err_range  out  1  sticky; a sample q>=MOD was detected.
- err_val  out  WIDTH  offending sample, latched at error entry.
- exp_val  out  WIDTH  expected value at error entry; 0 for a range error in SEARCH.

Behaviour:
- All outputs are registered.
- Reset (async, rst=1): state=SEARCH, prev=0; every output is 0. Reset mid-operation aborts immediately with no pending tc.
- FSM states: SEARCH, LOCKED, ERROR.
- Evaluation order, per rising edge:
  - If clr=1: clr takes priority and the sample is ignored. Go to SEARCH; clear wrap_count, err_seq, err_range, err_val, exp_val and prev; tc=0.
  - Else if en=0: hold all state; tc=0.
  - Else, evaluate the sample as described below.
- SEARCH:
  - q>=MOD -> ERROR; err_range=1, err_val=q, exp_val=0.
  - q==0 -> LOCKED, prev=0. No tc and no tally; lock-on is not a wrap.
  - Any other value is ignored and the state stays SEARCH.
- LOCKED:
  - Expected value: exp = (prev==MOD-1) ? 0 : prev+1.
  - The range check takes priority over the sequence check. q>=MOD -> ERROR; err_range=1, err_val=q, exp_val=exp; err_seq stays 0.
  - q==exp -> prev=q.
  - If q==0 (wrap): tc=1 next cycle; wrap_count increments unless it is already 2^CNT_W-1, in which case it holds.
  - q!=exp -> ERROR; err_seq=1, err_val=q, exp_val=exp; no tc.
  - A repeated value (q==prev) is a mismatch.
- ERROR:
  - Sticky; samples are ignored.
  - err_val, exp_val and wrap_count are frozen; locked=0; tc=0.
  - Only clr or rst exits this state.
- Latency: sample at edge k -> locked, tc and errors are visible after edge k.
- tc never asserts on two consecutive cycles when MOD>1.
- en gaps in LOCKED are legal. Checking resumes from prev, so the upstream counter must be stalled during the gap.

Test Plan:
- Reset, then run the counter freely from 0 with en=1 for 3*14+1 samples -> locked=1 after the first sample; tc pulses exactly 3 times, 14 cycles apart, each the cycle after a 13->0 sample; wrap_count=3; no errors.
- Start the counter at 9 with en=1 -> locked stays 0 for samples 9..13; lock occurs on the first 0; the first tc appears 14 samples later; wrap_count=1.
- While locked, drive sequence 4,5,7 -> err_seq=1, err_val=7, exp_val=6, locked=0; further samples leave all outputs frozen.
- While locked at prev=12, drive q=15 -> err_range=1, err_seq=0, err_val=15, exp_val=13. Then assert clr together with en=1 and q=0 -> the next cycle is SEARCH with all error flags and tally 0 (the sample is ignored); the next q=0 sample locks.
- Set CNT_W=3 and run 9 full periods -> wrap_count goes 1..7 and then holds at 7; tc still pulses on wraps 8 and 9.
- Assert rst asynchronously mid-LOCKED at q=13, one edge before a wrap -> outputs go to 0 immediately, with no tc after release; the block is in SEARCH and relocks on the next 0.
